// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit two's-complement adder/subtractor, carry chain cut into STAGES registered slices
// Stage k adds operand slice k; operand bits above slice k ride along until their stage consumes them.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] b_ent;
  logic             cin_ent;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // Subtract as A + ~B + 1; the caller's carry-in is ignored in that mode.
  assign b_ent    = sub ? ~b : b;
  assign cin_ent  = sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SW;
    localparam int UPW  = WIDTH - LO;
    localparam int SUMW = LO + SW;

    logic [UPW-1:0]  op_a;
    logic [UPW-1:0]  op_b;
    logic            cin;
    logic            vld_d;
    logic            vld_q;
    logic            cy_q;
    logic [SW:0]     slice;
    logic [SUMW-1:0] sum_d;
    logic [SUMW-1:0] sum_q;

    if (k == 0) begin : g_entry
      assign op_a  = a;
      assign op_b  = b_ent;
      assign cin   = cin_ent;
      assign vld_d = in_valid;
      assign sum_d = slice[SW-1:0];
    end else begin : g_chain
      assign op_a  = g_stage[k-1].g_fwd.a_q;
      assign op_b  = g_stage[k-1].g_fwd.b_q;
      assign cin   = g_stage[k-1].cy_q;
      assign vld_d = g_stage[k-1].vld_q;
      assign sum_d = {slice[SW-1:0], g_stage[k-1].sum_q};
    end

    assign slice = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        cy_q  <= slice[SW];
        sum_q <= sum_d;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [UPW-SW-1:0] a_q;
      logic [UPW-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= op_a[UPW-1:SW];
          b_q <= op_b[UPW-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // The top slice holds both operand MSBs (B already inverted for subtract).
      assign ovf_d = (op_a[SW-1] == op_b[SW-1]) && (slice[SW-1] != op_a[SW-1]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].vld_q;
  assign sum       = g_stage[LAST].sum_q;
  assign c_out     = g_stage[LAST].cy_q;
  assign ovf       = g_stage[LAST].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed bench for pipelined_adder (WIDTH=16, STAGES=4)
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb);
    in_valid = v;
    a        = aa;
    b        = bb;
    c_in     = ci;
    sub      = sb;
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ci, input logic sb,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    int cnt;
    drive(1'b1, aa, bb, ci, sb);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(S - 1));
    chk({tag, "_sum"},     32'(sum),   32'(es));
    chk({tag, "_c_out"},   32'(c_out), 32'(ec));
    chk({tag, "_ovf"},     32'(ovf),   32'(eo));
    tick();
  endtask

  int sched [9] = '{1, 2, 3, 0, 4, 5, 6, 7, 8};

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_c_out",     32'(c_out),     32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    run_vec("add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_vec("add_ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_vec("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_vec("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Streaming with one input gap after the third beat.
    for (int c = 0; c < 13; c++) begin
      int ev;
      if (c < 9 && sched[c] != 0)
        drive(1'b1, 16'(sched[c]), 16'(sched[c] * 32'h1000), 1'b0, 1'b0);
      else
        drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      ev = (c >= 3 && c - 3 < 9) ? sched[c - 3] : 0;
      chk($sformatf("stream_vld_c%0d", c), 32'(out_valid), 32'(ev != 0));
      if (ev != 0)
        chk($sformatf("stream_sum_c%0d", c), 32'(sum), 32'(16'(ev * 32'h1001)));
    end

    // Backpressure: fill, stall 5 cycles with junk offered, then drain.
    for (int j = 1; j <= 4; j++) begin
      drive(1'b1, 16'(j * 256), 16'(j), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready_now", 32'(in_ready),  32'd0);
    chk("stall_vld_now",      32'(out_valid), 32'd1);
    chk("stall_sum_now",      32'(sum),       32'h0101);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("stall_in_ready_%0d", s), 32'(in_ready),  32'd0);
      chk($sformatf("stall_vld_%0d", s),      32'(out_valid), 32'd1);
      chk($sformatf("stall_sum_%0d", s),      32'(sum),       32'h0101);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("drain_vld_%0d", j), 32'(out_valid), 32'd1);
      chk($sformatf("drain_sum_%0d", j), 32'(sum),       32'(16'(j * 32'h0101)));
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_empty_%0d", j), 32'(out_valid), 32'd0);
      tick();
    end

    // Reset with three beats in flight.
    for (int j = 1; j <= 3; j++) begin
      drive(1'b1, 16'(j), 16'(j), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_vld",      32'(out_valid), 32'd0);
    chk("midrst_sum",      32'(sum),       32'd0);
    chk("midrst_c_out",    32'(c_out),     32'd0);
    chk("midrst_in_ready", 32'(in_ready),  32'd1);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk($sformatf("midrst_no_stale_%0d", j), 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
